// File: rtl/memory_arbiter_if.sv
// Request/response handshake between the instruction cache, the data cache,
// the arbiter and the external memory port. The line buses are tristate and stay on the arbiter.
interface memory_arbiter_if #(
    parameter int WIDTH = 256,
    parameter int XLEN  = 32
);
    logic [XLEN-1:0]  instr_address;
    logic             instr_read;
    logic [WIDTH-1:0] instr_data;
    logic             instr_ready;
    logic [XLEN-1:0]  data_address;
    logic             data_read;
    logic             data_write;
    logic             data_ready;
    logic             data_done;
    logic [XLEN-1:0]  mem_address;
    logic             mem_read;
    logic             mem_write;
    logic             mem_ready;
    logic             mem_done;
    logic             timeout;

    modport slave (
        input  instr_address, instr_read, data_address, data_read, data_write,
               mem_ready, mem_done,
        output instr_data, instr_ready, data_ready, data_done,
               mem_address, mem_read, mem_write, timeout
    );

    modport master (
        output instr_address, instr_read, data_address, data_read, data_write,
               mem_ready, mem_done,
        input  instr_data, instr_ready, data_ready, data_done,
               mem_address, mem_read, mem_write, timeout
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory bus between the instruction and data caches.
// One transaction at a time, a one-cycle release gap after each, and an abort on a stalled memory.
module memory_arbiter #(
    parameter int WIDTH   = 256,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    memory_arbiter_if.slave   bus,
    inout  wire [WIDTH-1:0]   data_data,
    inout  wire [WIDTH-1:0]   mem_data
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, INSTR, DATA_RD, DATA_WR, RELEASE} state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;   // 1: data cache served last
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            busy, resp, expired, data_req;

    assign busy     = (state_q == INSTR) || (state_q == DATA_RD) || (state_q == DATA_WR);
    assign resp     = (state_q == DATA_WR) ? bus.mem_done : (busy && bus.mem_ready);
    // A response in the final cycle beats the abort.
    assign expired  = busy && !resp && (cnt_q == LAST);
    assign data_req = bus.data_read || bus.data_write;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.instr_read && (!data_req || last_grant_q)) begin
                    state_d      = INSTR;
                    last_grant_d = 1'b0;
                    cnt_d        = '0;
                    addr_d       = bus.instr_address;
                end else if (data_req) begin
                    state_d      = bus.data_write ? DATA_WR : DATA_RD;
                    last_grant_d = 1'b1;
                    cnt_d        = '0;
                    addr_d       = bus.data_address;
                end
            end
            INSTR, DATA_RD, DATA_WR: begin
                if (resp || expired) state_d = RELEASE;
                else                 cnt_d   = cnt_q + 1'b1;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
        end
    end

    assign bus.mem_address = addr_q;
    assign bus.mem_read    = (state_q == INSTR) || (state_q == DATA_RD);
    assign bus.mem_write   = (state_q == DATA_WR);
    assign bus.timeout     = expired;

    assign bus.instr_ready = (state_q == INSTR)   && bus.mem_ready;
    assign bus.data_ready  = (state_q == DATA_RD) && bus.mem_ready;
    assign bus.data_done   = (state_q == DATA_WR) && bus.mem_done;
    assign bus.instr_data  = (state_q == INSTR) ? mem_data : '0;

    // Each line bus is driven only while its transfer direction is active.
    assign data_data = (state_q == DATA_RD) ? mem_data  : {WIDTH{1'bz}};
    assign mem_data  = (state_q == DATA_WR) ? data_data : {WIDTH{1'bz}};
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset, single reads/writes, round-robin ties,
// timeout abort and boundary, mid-transaction reset and stray memory responses.
module tb_memory_arbiter;
  localparam int WIDTH = 256, XLEN = 32, TIMEOUT = 8;
  localparam logic [WIDTH-1:0] PAT_R = {32{8'hA5}};
  localparam logic [WIDTH-1:0] PAT_W = {8{32'h12345678}};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_arbiter_if #(.WIDTH(WIDTH), .XLEN(XLEN)) bus ();
  wire  [WIDTH-1:0] data_data, mem_data;
  logic [WIDTH-1:0] data_drv, mem_drv;
  logic             data_oe, mem_oe;
  assign data_data = data_oe ? data_drv : {WIDTH{1'bz}};
  assign mem_data  = mem_oe  ? mem_drv  : {WIDTH{1'bz}};

  memory_arbiter #(.WIDTH(WIDTH), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .data_data(data_data), .mem_data(mem_data)
  );

  int n_cmp = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle_inputs();
    bus.instr_address = '0; bus.instr_read = 1'b0;
    bus.data_address  = '0; bus.data_read  = 1'b0; bus.data_write = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_done = 1'b0;
    data_oe = 1'b0; mem_oe = 1'b0; data_drv = '0; mem_drv = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_inputs();
    @(negedge clk);
    n_cmp++; if ({bus.mem_read, bus.mem_write, bus.instr_ready, bus.data_ready, bus.data_done, bus.timeout} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 000000", {bus.mem_read, bus.mem_write, bus.instr_ready, bus.data_ready, bus.data_done, bus.timeout}); end
    n_cmp++; if (bus.mem_address !== '0 || bus.instr_data !== '0) begin
      n_fail++; $display("FAIL reset_bus: got addr %h data %h want 0", bus.mem_address, bus.instr_data); end
    data_oe = 1'b1; data_drv = PAT_W; #1;
    n_cmp++; if (mem_data === PAT_W) begin n_fail++; $display("FAIL reset_mem_hiz: got %h want z", mem_data); end
    data_oe = 1'b0; mem_oe = 1'b1; mem_drv = PAT_R; #1;
    n_cmp++; if (data_data === PAT_R) begin n_fail++; $display("FAIL reset_data_hiz: got %h want z", data_data); end
    mem_oe = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lone_instr();
    bus.instr_address = 32'h100; bus.instr_read = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus.mem_read, bus.mem_write} !== 2'b10 || bus.mem_address !== 32'h100) begin
      n_fail++; $display("FAIL instr_grant: got rd/wr %b addr %h want 10 00000100", {bus.mem_read, bus.mem_write}, bus.mem_address); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL instr_early_ready: got %b want 0", bus.instr_ready); end
    bus.mem_ready = 1'b1; mem_oe = 1'b1; mem_drv = PAT_R; #1;
    n_cmp++; if (bus.instr_ready !== 1'b1 || bus.instr_data !== PAT_R) begin
      n_fail++; $display("FAIL instr_ready: got %b data %h want 1 %h", bus.instr_ready, bus.instr_data, PAT_R); end
    @(negedge clk); bus.mem_ready = 1'b0; mem_oe = 1'b0; bus.instr_read = 1'b0; #1;
    n_cmp++; if (bus.mem_read !== 1'b0 || bus.instr_ready !== 1'b0 || bus.instr_data !== '0) begin
      n_fail++; $display("FAIL instr_release: got rd %b rdy %b data %h want 0 0 0", bus.mem_read, bus.instr_ready, bus.instr_data); end
    @(negedge clk);
  endtask

  task automatic test_tie_order();
    int last_cyc, t;
    logic [XLEN-1:0] exp_addr;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    bus.instr_address = 32'h40; bus.data_address = 32'h80;
    bus.instr_read = 1'b1; bus.data_read = 1'b1;
    last_cyc = 0;
    for (int g = 0; g < 3; g++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (bus.mem_read !== 1'b1 && t < 10);
      exp_addr = (g == 1) ? 32'h80 : 32'h40;
      n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_address !== exp_addr) begin
        n_fail++; $display("FAIL tie_grant%0d: got rd %b addr %h want 1 %h", g, bus.mem_read, bus.mem_address, exp_addr); end
      if (g > 0) begin
        n_cmp++; if (cyc - last_cyc !== 3) begin n_fail++; $display("FAIL tie_gap%0d: got %0d want 3", g, cyc - last_cyc); end
      end
      last_cyc = cyc;
      bus.mem_ready = 1'b1; mem_oe = 1'b1; mem_drv = PAT_R; #1;
      n_cmp++; if ({bus.instr_ready, bus.data_ready} !== ((g == 1) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL tie_ready%0d: got %b want %b", g, {bus.instr_ready, bus.data_ready}, (g == 1) ? 2'b01 : 2'b10); end
      @(negedge clk); bus.mem_ready = 1'b0; mem_oe = 1'b0;
    end
    bus.instr_read = 1'b0; bus.data_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_data_write();
    for (int v = 0; v < 2; v++) begin
      bus.data_address = (v == 0) ? 32'h2000 : 32'h3000;
      bus.data_write = 1'b1; bus.data_read = (v == 1); data_oe = 1'b1; data_drv = PAT_W;
      @(negedge clk);
      n_cmp++; if ({bus.mem_read, bus.mem_write} !== 2'b01 || bus.mem_address !== bus.data_address || mem_data !== PAT_W) begin
        n_fail++; $display("FAIL wr_grant%0d: got rd/wr %b addr %h data %h want 01 %h %h", v, {bus.mem_read, bus.mem_write}, bus.mem_address, mem_data, bus.data_address, PAT_W); end
      @(negedge clk); bus.mem_done = 1'b1; #1;
      n_cmp++; if ({bus.data_done, bus.data_ready, bus.instr_ready} !== 3'b100) begin
        n_fail++; $display("FAIL wr_done%0d: got %b want 100", v, {bus.data_done, bus.data_ready, bus.instr_ready}); end
      @(negedge clk); bus.mem_done = 1'b0; bus.data_write = 1'b0; bus.data_read = 1'b0; #1;
      n_cmp++; if (bus.mem_write !== 1'b0 || bus.data_done !== 1'b0 || mem_data === PAT_W) begin
        n_fail++; $display("FAIL wr_release%0d: got wr %b done %b data %h want 0 0 z", v, bus.mem_write, bus.data_done, mem_data); end
      data_oe = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    logic early;
    bus.data_address = 32'h500; bus.data_read = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h500) begin
      n_fail++; $display("FAIL to_grant: got rd %b addr %h want 1 00000500", bus.mem_read, bus.mem_address); end
    early = 1'b0;
    for (int j = 1; j < 7; j++) begin @(negedge clk); if (bus.timeout !== 1'b0) early = 1'b1; end
    n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", early); end
    @(negedge clk);
    n_cmp++; if (bus.timeout !== 1'b1 || bus.data_ready !== 1'b0) begin
      n_fail++; $display("FAIL to_pulse: got to %b rdy %b want 1 0", bus.timeout, bus.data_ready); end
    bus.instr_address = 32'h600; bus.instr_read = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.timeout !== 1'b0 || bus.mem_read !== 1'b0 || bus.data_ready !== 1'b0) begin
      n_fail++; $display("FAIL to_release: got to %b rd %b rdy %b want 0 0 0", bus.timeout, bus.mem_read, bus.data_ready); end
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h600) begin
      n_fail++; $display("FAIL to_next_tie: got rd %b addr %h want 1 00000600", bus.mem_read, bus.mem_address); end
    bus.mem_ready = 1'b1; @(negedge clk);
    bus.mem_ready = 1'b0; bus.instr_read = 1'b0; bus.data_read = 1'b0;
    @(negedge clk);
    bus.data_address = 32'h700; bus.data_read = 1'b1;
    repeat (8) @(negedge clk);
    bus.mem_ready = 1'b1; mem_oe = 1'b1; mem_drv = PAT_R; #1;
    n_cmp++; if (bus.data_ready !== 1'b1 || bus.timeout !== 1'b0 || data_data !== PAT_R) begin
      n_fail++; $display("FAIL to_boundary: got rdy %b to %b data %h want 1 0 %h", bus.data_ready, bus.timeout, data_data, PAT_R); end
    @(negedge clk); bus.mem_ready = 1'b0; mem_oe = 1'b0; bus.data_read = 1'b0; #1;
    n_cmp++; if (bus.timeout !== 1'b0 || bus.mem_read !== 1'b0) begin
      n_fail++; $display("FAIL to_boundary_rel: got to %b rd %b want 0 0", bus.timeout, bus.mem_read); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.data_address = 32'h2000; bus.data_write = 1'b1; data_oe = 1'b1; data_drv = PAT_W;
    @(negedge clk);
    n_cmp++; if (bus.mem_write !== 1'b1) begin n_fail++; $display("FAIL rst_mid_grant: got %b want 1", bus.mem_write); end
    reset = 1'b1; bus.mem_done = 1'b1; #1;
    n_cmp++; if (bus.mem_write !== 1'b0 || bus.data_done !== 1'b0 || mem_data === PAT_W) begin
      n_fail++; $display("FAIL rst_mid: got wr %b done %b data %h want 0 0 z", bus.mem_write, bus.data_done, mem_data); end
    @(negedge clk); reset = 1'b0; bus.mem_done = 1'b0;
    bus.instr_address = 32'h100; bus.instr_read = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h100) begin
      n_fail++; $display("FAIL rst_mid_tie: got rd %b addr %h want 1 00000100", bus.mem_read, bus.mem_address); end
    bus.mem_ready = 1'b1; @(negedge clk);
    bus.mem_ready = 1'b0; bus.instr_read = 1'b0; bus.data_write = 1'b0; data_oe = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stray();
    bus.data_address = 32'h900; bus.data_read = 1'b1;
    @(negedge clk);
    bus.mem_done = 1'b1; mem_oe = 1'b1; mem_drv = PAT_R; #1;
    n_cmp++; if ({bus.data_ready, bus.data_done, bus.instr_ready} !== 3'b000 || bus.instr_data !== '0) begin
      n_fail++; $display("FAIL stray_done: got %b idata %h want 000 0", {bus.data_ready, bus.data_done, bus.instr_ready}, bus.instr_data); end
    @(negedge clk); bus.mem_done = 1'b0;
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h900) begin
      n_fail++; $display("FAIL stray_hold: got rd %b addr %h want 1 00000900", bus.mem_read, bus.mem_address); end
    bus.mem_ready = 1'b1; #1;
    n_cmp++; if (bus.data_ready !== 1'b1) begin n_fail++; $display("FAIL stray_complete: got %b want 1", bus.data_ready); end
    @(negedge clk); bus.mem_ready = 1'b0; bus.data_read = 1'b0;
    @(negedge clk);
    bus.mem_ready = 1'b1; #1;
    n_cmp++; if ({bus.instr_ready, bus.data_ready, bus.data_done} !== 3'b000) begin
      n_fail++; $display("FAIL stray_idle: got %b want 000", {bus.instr_ready, bus.data_ready, bus.data_done}); end
    @(negedge clk); bus.mem_ready = 1'b0; mem_oe = 1'b0;
    n_cmp++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin
      n_fail++; $display("FAIL stray_idle_hold: got %b want 00", {bus.mem_read, bus.mem_write}); end
  endtask

  initial begin
    test_reset();
    test_lone_instr();
    test_tie_order();
    test_data_write();
    test_timeout();
    test_reset_mid();
    test_stray();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
